// File: rtl/sample_reader.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// sample_reader
//
// Streams a finished capture out of the sample memory over the shared UART
// transmitter. A rising edge on activate starts a packet of the form
//   HEADER, mem[start_addr], mem[start_addr+1], ..., checksum
// where checksum is the 8-bit sum of the samples only. The address wraps
// modulo 2^ADDR_WIDTH. done is held high until activate is released.
//
// Ports:
//   clk_50mhz    system clock
//   reset        asynchronous active-low reset
//   activate     level from the state watcher; rising edge starts a packet
//   done         packet complete; held until activate drops
//   start_addr   first sample address (latched at start)
//   sample_count number of samples, 0..2^ADDR_WIDTH (latched at start)
//   mem_addr     sample memory read address
//   mem_oe       sample memory output enable (high only while fetching)
//   mem_data     sample memory read data (asynchronous read)
//   tx_data      byte presented to uart_tx
//   tx_start     one-cycle start pulse to uart_tx
//   tx_active    uart_tx busy
//   tx_done      uart_tx one-cycle completion pulse
//   busy         high in every state except IDLE and DONE
// -----------------------------------------------------------------------------
module sample_reader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [7:0]  HEADER     = 8'hA5
) (
  input  logic                  clk_50mhz,
  input  logic                  reset,
  input  logic                  activate,
  output logic                  done,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   sample_count,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_oe,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_active,
  input  logic                  tx_done,
  output logic                  busy
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEND_HDR,
    ST_WAIT_HDR,
    ST_FETCH,
    ST_SEND_SMP,
    ST_WAIT_SMP,
    ST_SEND_SUM,
    ST_WAIT_SUM,
    ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  act_q, act_d;
  logic                  abort_q, abort_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic [7:0]            checksum_q, checksum_d;
  logic [DATA_WIDTH-1:0] sample_q, sample_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_oe_q, mem_oe_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;

  logic start;
  logic dropped;

  // Edge against the registered copy of activate. act_q resets to 1 so that a
  // level already high when reset releases is not mistaken for a new edge.
  assign start   = activate && !act_q;
  // Once activate has fallen mid-packet the packet is abandoned; the sticky
  // flag remembers a short low glitch until the in-flight byte finishes.
  assign dropped = abort_q || !activate;

  assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done     = (state_q == ST_DONE);
  assign mem_addr = mem_addr_q;
  assign mem_oe   = mem_oe_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    act_d       = activate;
    abort_d     = abort_q || (busy && !activate);
    addr_d      = addr_q;
    remaining_d = remaining_q;
    checksum_d  = checksum_q;
    sample_d    = sample_q;
    mem_addr_d  = mem_addr_q;
    mem_oe_d    = 1'b0;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          addr_d      = start_addr;
          remaining_d = sample_count;
          checksum_d  = '0;
          state_d     = ST_SEND_HDR;
        end
      end

      ST_SEND_HDR: begin
        if (dropped) begin
          state_d = ST_IDLE;
        end else if (!tx_active) begin
          tx_data_d  = HEADER;
          tx_start_d = 1'b1;
          state_d    = ST_WAIT_HDR;
        end
      end

      ST_WAIT_HDR, ST_WAIT_SMP: begin
        if (tx_done) begin
          if (dropped) begin
            state_d = ST_IDLE;
          end else if (remaining_q != '0) begin
            // Address and enable are registered here so they are valid for
            // the whole FETCH cycle.
            mem_addr_d = addr_q;
            mem_oe_d   = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_SEND_SUM;
          end
        end
      end

      ST_FETCH: begin
        sample_d = mem_data;
        state_d  = ST_SEND_SMP;
      end

      ST_SEND_SMP: begin
        if (dropped) begin
          state_d = ST_IDLE;
        end else if (!tx_active) begin
          tx_data_d   = 8'(sample_q);
          tx_start_d  = 1'b1;
          checksum_d  = checksum_q + 8'(sample_q);
          addr_d      = addr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - (ADDR_WIDTH + 1)'(1);
          state_d     = ST_WAIT_SMP;
        end
      end

      ST_SEND_SUM: begin
        if (dropped) begin
          state_d = ST_IDLE;
        end else if (!tx_active) begin
          tx_data_d  = checksum_q;
          tx_start_d = 1'b1;
          state_d    = ST_WAIT_SUM;
        end
      end

      ST_WAIT_SUM: begin
        if (tx_done) begin
          state_d = dropped ? ST_IDLE : ST_DONE;
        end
      end

      ST_DONE: begin
        if (!activate) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      act_q       <= 1'b1;
      abort_q     <= 1'b0;
      addr_q      <= '0;
      remaining_q <= '0;
      checksum_q  <= '0;
      sample_q    <= '0;
      mem_addr_q  <= '0;
      mem_oe_q    <= 1'b0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      abort_q     <= abort_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      checksum_q  <= checksum_d;
      sample_q    <= sample_d;
      mem_addr_q  <= mem_addr_d;
      mem_oe_q    <= mem_oe_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
    end
  end

endmodule

// File: tb/tb_sample_reader.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_sample_reader
//
// Scoreboard bench: directed packets push their hand-computed byte streams
// into exp_q; a monitor pops one entry per tx_start pulse and compares. A
// small UART model answers tx_start with a busy window and a tx_done pulse,
// and can hold tx_active high for a long stretch after a chosen byte.
// -----------------------------------------------------------------------------
module tb_sample_reader;

  logic       clk_50mhz = 1'b0;
  logic       reset;
  logic       activate;
  logic       done;
  logic [7:0] start_addr;
  logic [8:0] sample_count;
  logic [7:0] mem_addr;
  logic       mem_oe;
  logic [7:0] mem_data;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_active;
  logic       tx_done;
  logic       busy;

  always #10 clk_50mhz = ~clk_50mhz;

  logic [7:0] mem [256];
  assign mem_data = mem[mem_addr];

  logic uart_busy;
  logic force_busy;
  assign tx_active = uart_busy | force_busy;

  int total = 0;
  int bad   = 0;
  int viol  = 0;        // protocol violations (double pulse, pulse while busy, data not held)
  int bytes_seen = 0;
  int oe_cycles  = 0;
  int done_seen  = 0;
  int force_next = 0;
  int force_cnt  = 0;
  logic start_pending = 1'b0;
  logic [7:0] exp_q [$];

  sample_reader #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8),
    .HEADER    (8'hA5)
  ) dut (
    .clk_50mhz   (clk_50mhz),
    .reset       (reset),
    .activate    (activate),
    .done        (done),
    .start_addr  (start_addr),
    .sample_count(sample_count),
    .mem_addr    (mem_addr),
    .mem_oe      (mem_oe),
    .mem_data    (mem_data),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_active   (tx_active),
    .tx_done     (tx_done),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard.
  initial begin
    logic       inflight;
    logic       prev_start;
    logic [7:0] held;
    inflight   = 1'b0;
    prev_start = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk_50mhz);
      if (!reset) begin
        inflight   = 1'b0;
        prev_start = 1'b0;
      end else begin
        if (mem_oe) oe_cycles++;
        if (done) done_seen++;
        if (tx_start) begin
          if (prev_start || tx_active) viol++;
          bytes_seen++;
          if (exp_q.size() == 0) check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
          else check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
          held          = tx_data;
          inflight      = 1'b1;
          start_pending = 1'b1;
        end
        if (tx_done && inflight) begin
          if (tx_data !== held) viol++;
          inflight = 1'b0;
        end
        prev_start = tx_start;
      end
    end
  end

  // UART model: 6-cycle busy window per byte, tx_done on the last cycle.
  initial begin
    int cnt;
    cnt        = 0;
    uart_busy  = 1'b0;
    force_busy = 1'b0;
    tx_done    = 1'b0;
    forever begin
      @(posedge clk_50mhz);
      #1;
      tx_done = 1'b0;
      if (force_cnt > 0) begin
        force_cnt--;
        if (force_cnt == 0) force_busy = 1'b0;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          uart_busy = 1'b0;
          tx_done   = 1'b1;
          if (force_next > 0) begin
            force_busy = 1'b1;
            force_cnt  = force_next;
            force_next = 0;
          end
        end
      end else if (start_pending) begin
        start_pending = 1'b0;
        uart_busy     = 1'b1;
        cnt           = 6;
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_done"},     32'(done),     32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_tx_data"},  32'(tx_data),  32'd0);
    check({tag, "_mem_oe"},   32'(mem_oe),   32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
  endtask

  task automatic push_bytes(input logic [7:0] b [], input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(b[i]);
  endtask

  // Raise activate, then scramble the address/count inputs to prove latching.
  task automatic start_packet(input logic [7:0] sa, input logic [8:0] cnt);
    @(negedge clk_50mhz);
    start_addr   = sa;
    sample_count = cnt;
    activate     = 1'b1;
    @(negedge clk_50mhz);
    check("busy_after_start", 32'(busy), 32'd1);
    start_addr   = ~sa;
    sample_count = 9'h155;
  endtask

  task automatic finish_packet(input string name);
    int n;
    n = 0;
    while (!done && n < 5000) begin
      @(negedge clk_50mhz);
      n++;
    end
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_all_bytes"}, 32'(exp_q.size()), 32'd0);
    activate = 1'b0;
    @(negedge clk_50mhz);
    check({name, "_done_clr"}, 32'(done), 32'd0);
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] b [];
    int n;
    int base;
    int lat;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    reset        = 1'b0;
    activate     = 1'b1;
    start_addr   = 8'h00;
    sample_count = 9'd0;

    // Reset values, and no start from a level already high at release.
    repeat (3) @(negedge clk_50mhz);
    check_reset_vals("rst");
    reset = 1'b1;
    repeat (20) @(negedge clk_50mhz);
    check("level_no_start_busy", 32'(busy), 32'd0);
    check("level_no_start_bytes", 32'(bytes_seen), 32'd0);
    activate = 1'b0;
    @(negedge clk_50mhz);

    // Basic packet: mem[i]=i, 4 samples from 0.
    b = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h06};
    push_bytes(b, 6);
    oe_cycles = 0;
    start_packet(8'h00, 9'd4);
    finish_packet("basic");
    check("basic_oe_cycles", 32'(oe_cycles), 32'd4);

    // Address and checksum wrap.
    mem[8'hFE] = 8'h10; mem[8'hFF] = 8'h20; mem[8'h00] = 8'h30; mem[8'h01] = 8'h40;
    b = '{8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA0};
    push_bytes(b, 6);
    start_packet(8'hFE, 9'd4);
    finish_packet("wrap");

    // Zero samples: header plus zero checksum, memory never enabled.
    b = '{8'hA5, 8'h00};
    push_bytes(b, 2);
    oe_cycles = 0;
    start_packet(8'h40, 9'd0);
    finish_packet("zero");
    check("zero_oe_cycles", 32'(oe_cycles), 32'd0);

    // tx_active held high for 500 cycles after the header.
    b = '{8'hA5, 8'h10, 8'h11, 8'h21};
    push_bytes(b, 4);
    force_next = 500;
    start_packet(8'h10, 9'd2);
    n = 0;
    while (!force_busy && n < 200) begin @(negedge clk_50mhz); n++; end
    check("force_seen", 32'(force_busy), 32'd1);
    n = 0;
    while (force_busy && n < 700) begin @(negedge clk_50mhz); n++; end
    check("force_released", 32'(force_busy), 32'd0);
    lat = 0;
    do begin
      @(negedge clk_50mhz);
      lat++;
    end while (!tx_start && lat < 10);
    check("start_after_release", 32'(lat), 32'd1);
    finish_packet("force");

    // activate dropped during the third sample.
    b = '{8'hA5, 8'h20, 8'h21, 8'h22};
    push_bytes(b, 4);
    done_seen = 0;
    base      = bytes_seen;
    start_packet(8'h20, 9'd8);
    n = 0;
    while (bytes_seen < base + 4 && n < 2000) begin @(negedge clk_50mhz); n++; end
    check("abort_reached_3rd", 32'(bytes_seen - base), 32'd4);
    activate = 1'b0;
    repeat (100) @(negedge clk_50mhz);
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_no_more_bytes", 32'(bytes_seen - base), 32'd4);
    check("abort_queue", 32'(exp_q.size()), 32'd0);

    // Reset pulsed during the second sample, then a full packet.
    b = '{8'hA5, 8'h30, 8'h31};
    push_bytes(b, 3);
    base = bytes_seen;
    start_packet(8'h30, 9'd4);
    n = 0;
    while (bytes_seen < base + 3 && n < 2000) begin @(negedge clk_50mhz); n++; end
    check("rst_mid_reached_2nd", 32'(bytes_seen - base), 32'd3);
    #3;
    reset    = 1'b0;
    activate = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    repeat (2) @(negedge clk_50mhz);
    reset = 1'b1;
    n = 0;
    while (tx_active && n < 50) begin @(negedge clk_50mhz); n++; end
    repeat (3) @(negedge clk_50mhz);
    check("rst_mid_no_extra", 32'(bytes_seen - base), 32'd3);
    b = '{8'hA5, 8'h30, 8'h31, 8'h32, 8'h33, 8'hC6};
    push_bytes(b, 6);
    start_packet(8'h30, 9'd4);
    finish_packet("after_rst");

    // Full depth: every address once starting at 0x80, sum 0..255 = 0x80.
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(8'h80 + i));
    exp_q.push_back(8'h80);
    oe_cycles = 0;
    start_packet(8'h80, 9'd256);
    finish_packet("full");
    check("full_oe_cycles", 32'(oe_cycles), 32'd256);

    check("protocol_violations", 32'(viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
